// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bundle for the execute-stage ALU.
package alu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_SLTU  = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor; sub_i computes a + ~b + 1.
module alu_addsub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    always_comb begin
        b_eff      = sub_i ? ~b_i : b_i;
        full       = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
        sum_o      = full[WIDTH-1:0];
        carry_o    = full[WIDTH];
        // Same-sign operands (after inversion) yielding a different-sign sum.
        overflow_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// Registered RV32I ALU with Z/C/N/V flags. Define ALU_SLT_EN to implement SLT/SLTU;
// otherwise those opcodes return zero with all flags clear except Z.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       ALUControl_i,
    input  logic [WIDTH-1:0] srcA_i,
    input  logic [WIDTH-1:0] srcB_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             carrayOut_o,
    output logic             negative_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] sum;
    logic             as_carry;
    logic             as_ovf;
    logic             sub;

    logic [WIDTH-1:0] result_d, result_q;
    alu_flags_t       flags_d, flags_q;

    assign sub = (ALUControl_i != ALU_ADD);

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a_i       (srcA_i),
        .b_i       (srcB_i),
        .sub_i     (sub),
        .sum_o     (sum),
        .carry_o   (as_carry),
        .overflow_o(as_ovf)
    );

    always_comb begin
        result_d  = '0;
        flags_d   = '0;
        unique case (ALUControl_i)
            ALU_ADD, ALU_SUB: begin
                result_d  = sum;
                flags_d.c = as_carry;
                flags_d.v = as_ovf;
            end
            ALU_AND:   result_d = srcA_i & srcB_i;
            ALU_OR:    result_d = srcA_i | srcB_i;
            ALU_XOR:   result_d = srcA_i ^ srcB_i;
`ifdef ALU_SLT_EN
            ALU_SLT: begin
                result_d  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ as_ovf};
                flags_d.c = as_carry;
                flags_d.v = as_ovf;
            end
            ALU_SLTU: begin
                result_d  = {{(WIDTH-1){1'b0}}, ~as_carry};
                flags_d.c = as_carry;
                flags_d.v = as_ovf;
            end
`else
            ALU_SLT, ALU_SLTU: result_d = '0;
`endif
            ALU_PASSB: result_d = srcB_i;
            default:   result_d = '0;
        endcase
        flags_d.z = (result_d == '0);
        flags_d.n = result_d[WIDTH-1];
    end

    // Reset forces constants, so unknown inputs never reach the registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result_o    = result_q;
    assign zero_o      = flags_q.z;
    assign carrayOut_o = flags_q.c;
    assign negative_o  = flags_q.n;
    assign overflow_o  = flags_q.v;

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of the ALU against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        n;
        logic        v;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic [W-1:0]  res;
    logic          z, c, n, v;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu #(W) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ALUControl_i(op),
        .srcA_i      (a),
        .srcB_i      (b),
        .result_o    (res),
        .zero_o      (z),
        .carrayOut_o (c),
        .negative_o  (n),
        .overflow_o  (v)
    );

    function automatic exp_t mk(logic [31:0] r, logic zz, logic cc, logic nn, logic vv);
        exp_t e;
        e.r = r; e.z = zz; e.c = cc; e.n = nn; e.v = vv;
        return e;
    endfunction

    // Reference: signed/unsigned integer arithmetic on 64-bit values.
    function automatic exp_t model(logic [2:0] o, logic [31:0] x, logic [31:0] y);
        exp_t        e;
        longint      sx, sy, s;
        logic [63:0] ux, uy, t;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        e  = '0;
        case (o)
            ALU_ADD: begin
                t = ux + uy;
                s = sx + sy;
                e.r = t[31:0];
                e.c = t[32];
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SUB: begin
                s = sx - sy;
                e.r = x - y;
                e.c = (ux >= uy);
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_AND:   e.r = x & y;
            ALU_OR:    e.r = x | y;
            ALU_XOR:   e.r = x ^ y;
`ifdef ALU_SLT_EN
            ALU_SLT, ALU_SLTU: begin
                s = sx - sy;
                e.r = (o == ALU_SLT) ? {31'b0, sx < sy} : {31'b0, ux < uy};
                e.c = (ux >= uy);
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
`else
            ALU_SLT, ALU_SLTU: e.r = 32'b0;
`endif
            default:   e.r = y;
        endcase
        e.z = (e.r == 32'b0);
        e.n = e.r[31];
        return e;
    endfunction

    task automatic step(input string tag, input logic r, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y, input exp_t e);
        @(negedge clk);
        rst = r; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        tests++;
        assert ({res, z, c, n, v} === e) else begin
            fails++;
            $error("FAIL %s: got r=%h zcnv=%b%b%b%b, expected r=%h zcnv=%b%b%b%b", tag,
                   res, z, c, n, v, e.r, e.z, e.c, e.n, e.v);
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; op = '0; a = '0; b = '0;

        for (int i = 0; i < 5; i++) begin
            step("reset_hold", 1'b1, 3'($urandom), $urandom, $urandom, '0);
        end

        step("add_basic", 1'b0, ALU_ADD, 32'h01234567, 32'h11111111,
             mk(32'h12345678, 0, 0, 0, 0));
        step("sub_borrow", 1'b0, ALU_SUB, 32'h01234567, 32'h11111111,
             mk(32'hF0123456, 0, 0, 1, 0));
        step("sub_noborrow", 1'b0, ALU_SUB, 32'h11111111, 32'h01234567,
             mk(32'h0FEDCBAA, 0, 1, 0, 0));
        step("and", 1'b0, ALU_AND, 32'h01234567, 32'h11111111, mk(32'h01010101, 0, 0, 0, 0));
        step("xor", 1'b0, ALU_XOR, 32'h01234567, 32'h11111111, mk(32'h10325476, 0, 0, 0, 0));
        step("or", 1'b0, ALU_OR, 32'h01234567, 32'h11111111, mk(32'h11335577, 0, 0, 0, 0));
        step("xor_zero", 1'b0, ALU_XOR, 32'h01234567, 32'h01234567, mk(32'h0, 1, 0, 0, 0));
        step("add_sovf", 1'b0, ALU_ADD, 32'h7FFFFFFF, 32'h1, mk(32'h80000000, 0, 0, 1, 1));
        step("add_wrap", 1'b0, ALU_ADD, 32'hFFFFFFFF, 32'h1, mk(32'h0, 1, 1, 0, 0));
        step("sub_sovf", 1'b0, ALU_SUB, 32'h80000000, 32'h1, mk(32'h7FFFFFFF, 0, 1, 0, 1));
`ifdef ALU_SLT_EN
        step("slt", 1'b0, ALU_SLT, 32'hFFFFFFFF, 32'h1, mk(32'h1, 0, 1, 0, 0));
        step("sltu", 1'b0, ALU_SLTU, 32'hFFFFFFFF, 32'h1, mk(32'h0, 1, 1, 0, 0));
`else
        step("slt_off", 1'b0, ALU_SLT, 32'hFFFFFFFF, 32'h1, mk(32'h0, 1, 0, 0, 0));
        step("sltu_off", 1'b0, ALU_SLTU, 32'hFFFFFFFF, 32'h1, mk(32'h0, 1, 0, 0, 0));
`endif
        step("passb", 1'b0, ALU_PASSB, 32'h12345678, 32'hDEADBEEF, mk(32'hDEADBEEF, 0, 0, 1, 0));

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = (i % 7 == 0) ? ra : $urandom;
            if (i == 30) begin
                step("reset_pulse", 1'b1, ro, ra, rb, '0);
            end else begin
                step("random", 1'b0, ro, ra, rb, model(ro, ra, rb));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Parameterised integer ALU for the RV32I core's execute stage. It takes two operands and a 3-bit operation code and produces a result plus four status flags: zero, carry, negative and overflow. The branch and compare logic consumes these flags. All outputs are registered on the single core clock.

## Interface
- `WIDTH`, default 32: operand and result width in bits. It is the first (positional) parameter and must be ≥ 2.
- `clk_i`  input  1  core clock. One clock; reset is synchronous and active-high.
- `rst_i`  input  1  synchronous active-high reset, sampled on the `clk_i` rising edge.
- `ALUControl_i`  input  3  operation select.
- `srcA_i`  input  WIDTH  operand A.
- `srcB_i`  input  WIDTH  operand B.
- `result_o`  output  WIDTH  registered result.
- `zero_o`  output  1  registered; 1 when the result is all zeros.
- `carrayOut_o`  output  1  registered carry flag. The port name is spelled this way on purpose.
- `negative_o`  output  1  registered; equals `result[WIDTH-1]`.
- `overflow_o`  output  1  registered signed-overflow flag.

## Operation
- Opcodes:
  - 000 ADD: A+B
  - 001 SUB: A−B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: signed A<B gives 1, else 0
  - 110 SLTU: unsigned A<B gives 1, else 0
  - 111 PASSB: result = B
- All arithmetic is modulo 2^WIDTH.
- SUB, SLT and SLTU use one internal subtractor computed as A + ~B + 1.
- Carry flag:
  - ADD: carry-out of bit WIDTH-1.
  - SUB, SLT, SLTU: carry-out of A + ~B + 1, so 1 means no borrow (A ≥ B unsigned).
  - Logic ops and PASSB: 0.
- Overflow flag:
  - ADD: A and B have the same sign and the sum's sign differs from it.
  - SUB, SLT, SLTU: A and B have different signs and the difference's sign differs from A's sign.
  - Otherwise: 0.
- SLT result = N_sub XOR V_sub. SLTU result = NOT C_sub.
- `zero_o` and `negative_o` always reflect the final `result_o`, whatever the opcode.

## Timing
- Latency is exactly 1 cycle. Inputs sampled at edge k appear on all outputs after edge k.
- Throughput is one operation per cycle. There is no handshake and no stall.
- Reset: while `rst_i`=1 at a rising edge, all outputs become 0 on that edge, including `zero_o` (0, not 1). This holds even if an operation is mid-flight: that operation is discarded.
- On the first edge after reset deasserts, the outputs load the current inputs.
- X or unknown inputs during reset must not propagate to the outputs.

## Configuration
- `ALU_SLT_EN`
  - Defined: SLT and SLTU are implemented as specified.
  - Undefined: opcodes 101 and 110 produce result 0, carry 0, overflow 0, zero 1, negative 0. This saves the compare logic. All other opcodes are unchanged.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode localparams: `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_XOR`, `ALU_SLT`, `ALU_SLTU`, `ALU_PASSB`;
  - a flags struct {z, c, n, v}.
- One sub-module, `alu_addsub`: combinational WIDTH-bit adder/subtractor. It outputs sum, carry and overflow; a `sub` input inverts B and sets carry-in.
- The top level holds the op mux, flag generation and output registers.

## Test plan
- Reset held for 5 cycles with random inputs: every output is 0 throughout. On release, ADD 0x01234567 + 0x11111111 gives result 0x12345678 one cycle later, with Z=0 N=0 C=0 V=0.
- SUB 0x01234567 − 0x11111111 gives 0xF0123456 with N=1, C=0 (borrow), V=0. SUB 0x11111111 − 0x01234567 gives 0x0FEDCBAA with C=1.
- Logic ops on A=0x01234567, B=0x11111111:
  - AND gives 0x01010101.
  - XOR gives 0x10325476.
  - OR gives 0x11335577.
  - XOR A=B=0x01234567 gives 0 with Z=1.
  - C and V are 0 in every case.
- Boundaries:
  - ADD 0x7FFFFFFF + 1 gives 0x80000000 with V=1, N=1, C=0.
  - ADD 0xFFFFFFFF + 1 gives 0 with Z=1, C=1, V=0.
  - SUB 0x80000000 − 1 gives 0x7FFFFFFF with V=1.
- Compares (with `ALU_SLT_EN`) on A=0xFFFFFFFF, B=1:
  - SLT gives 1.
  - SLTU gives 0.
  - Without the macro, both give 0 with Z=1.
  - PASSB with B=0xDEADBEEF gives 0xDEADBEEF with N=1.
- Back-to-back operations with a new opcode every cycle, then `rst_i` pulsed for one cycle mid-stream: the outputs track the inputs with a 1-cycle lag, and the reset cycle yields all-zero outputs.
